// File: rtl/fractal_pkg.sv
// Shared types and default frame dimensions for the fractal result readout path.
package fractal_pkg;

  localparam int unsigned DefNumSolvers = 7;
  localparam int unsigned DefNumColumns = 99;
  localparam int unsigned DefNumRows    = 66;
  localparam int unsigned DefIdW        = 6;
  localparam int unsigned DefAddrW      = 19;
  localparam int unsigned DefDataW      = 10;
  localparam int unsigned DefRdLat      = 2;
  localparam int unsigned DefFifoDepth  = 4;

  localparam int unsigned ColW = 11;
  localparam int unsigned RowW = 10;

  typedef struct packed {
    logic [ColW-1:0] col;
    logic [RowW-1:0] row;
    logic            sof;
    logic            eol;
    logic            eof;
  } pix_tag_t;

  localparam int unsigned TagW = $bits(pix_tag_t);

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDrain
  } rd_state_e;

endpackage

// File: rtl/sync_fwft_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is visible whenever not empty.
module sync_fwft_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop, full;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(DEPTH));
  assign do_pop   = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr_q];
  assign count    = count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr_q] <= push_data;
        wr_ptr_q      <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

endmodule

// File: rtl/pixel_stream_reader.sv
// Raster-order readout of the solver result memories into a framed valid/ready pixel stream.
// Reads are credit-limited against FIFO occupancy plus in-flight reads, so the FIFO never overflows.
module pixel_stream_reader
  import fractal_pkg::*;
#(
  parameter int unsigned NUM_SOLVERS = DefNumSolvers,
  parameter int unsigned NUM_COLUMNS = DefNumColumns,
  parameter int unsigned NUM_ROWS    = DefNumRows,
  parameter int unsigned ID_W        = DefIdW,
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned RD_LAT      = DefRdLat,
  parameter int unsigned FIFO_DEPTH  = DefFifoDepth
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              en,
  output logic              rd_en,
  output logic [ID_W-1:0]   rd_solver_id,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ColW-1:0]   out_col,
  output logic [RowW-1:0]   out_row,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned InflW  = $clog2(RD_LAT + 1);
  localparam int unsigned EntryW = TagW + DATA_W;

  rd_state_e         state_q, state_d;
  logic              done_q, done_d;
  logic [ColW-1:0]   col_q;
  logic [RowW-1:0]   row_q;
  logic [ID_W-1:0]   sid_q;
  logic [ADDR_W-1:0] addr_q;
  logic              last_col, last_row, last_sid, last_pix;
  pix_tag_t          cur_tag;
  logic [RD_LAT-1:0] vld_q;
  pix_tag_t          tag_q [RD_LAT];
  logic [InflW-1:0]  inflight;
  logic [CntW-1:0]   fifo_count;
  logic              fifo_empty, pop, credit_ok;
  logic [EntryW-1:0] push_data, head;
  pix_tag_t          head_tag;

  assign last_col = (col_q == ColW'(NUM_COLUMNS - 1));
  assign last_row = (row_q == RowW'(NUM_ROWS - 1));
  assign last_sid = (sid_q == ID_W'(NUM_SOLVERS - 1));
  assign last_pix = last_col && last_row;

  assign cur_tag = '{col: col_q, row: row_q, sof: (col_q == '0) && (row_q == '0),
                     eol: last_col, eof: last_pix};

  assign rd_solver_id = sid_q;
  assign rd_addr      = addr_q;
  assign busy         = (state_q != StIdle);
  assign done         = done_q;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(RD_LAT); i++) inflight = inflight + InflW'(vld_q[i]);
  end

  assign credit_ok = (32'(fifo_count) + 32'(inflight)) < FIFO_DEPTH;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    rd_en   = 1'b0;
    unique case (state_q)
      StIdle: if (start) state_d = StScan;
      StScan: begin
        rd_en = en && credit_ok;
        if (rd_en && last_pix) state_d = StDrain;
      end
      StDrain: begin
        // Leave on the cycle the final entry is popped so done lands right after it.
        if (inflight == '0 && (fifo_count == '0 || (fifo_count == CntW'(1) && pop))) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Pixel index split into (col,row) and (solver,addr) by paired wrapping counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_q  <= '0;
      row_q  <= '0;
      sid_q  <= '0;
      addr_q <= '0;
    end else if (rd_en) begin
      if (last_pix) begin
        col_q  <= '0;
        row_q  <= '0;
        sid_q  <= '0;
        addr_q <= '0;
      end else begin
        col_q <= last_col ? '0 : col_q + 1'b1;
        if (last_col) row_q <= row_q + 1'b1;
        sid_q <= last_sid ? '0 : sid_q + 1'b1;
        if (last_sid) addr_q <= addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) tag_q[i] <= '0;
    end else begin
      vld_q[0] <= rd_en;
      tag_q[0] <= cur_tag;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign push_data = {tag_q[RD_LAT-1], rd_data};
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  sync_fwft_fifo #(
    .WIDTH(EntryW),
    .DEPTH(FIFO_DEPTH)
  ) u_out_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (vld_q[RD_LAT-1]),
    .push_data(push_data),
    .pop      (pop),
    .pop_data (head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign head_tag = pix_tag_t'(head[EntryW-1:DATA_W]);
  assign out_data = out_valid ? head[DATA_W-1:0] : '0;
  assign out_col  = out_valid ? head_tag.col : '0;
  assign out_row  = out_valid ? head_tag.row : '0;
  assign out_sof  = out_valid && head_tag.sof;
  assign out_eol  = out_valid && head_tag.eol;
  assign out_eof  = out_valid && head_tag.eof;

endmodule

// File: tb/tb_pixel_stream_reader.sv
// Directed bench: a 4x2 frame over 3 solvers for most scenarios, plus one full default-size frame.
module tb_pixel_stream_reader;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  function automatic logic [9:0] mem_val(input int id, input int addr);
    return 10'(id * 89 + addr * 7 + 3);
  endfunction

  // Small instance: 3 solvers, 4 columns, 2 rows.
  logic        s_start = 1'b0, s_en = 1'b0, s_ready = 1'b0;
  logic        s_rd_en, s_valid, s_sof, s_eol, s_eof, s_busy, s_done;
  logic [5:0]  s_id;
  logic [18:0] s_addr;
  logic [9:0]  s_rd_data, s_data, s_row;
  logic [10:0] s_col;
  logic [5:0]  s_p0_id = '0, s_p1_id = '0;
  logic [18:0] s_p0_ad = '0, s_p1_ad = '0;

  always @(posedge clock) begin
    s_p0_id <= s_id;
    s_p0_ad <= s_addr;
    s_p1_id <= s_p0_id;
    s_p1_ad <= s_p0_ad;
  end
  assign s_rd_data = mem_val(int'(s_p1_id), int'(s_p1_ad));

  pixel_stream_reader #(
    .NUM_SOLVERS(3), .NUM_COLUMNS(4), .NUM_ROWS(2), .ID_W(6), .ADDR_W(19),
    .DATA_W(10), .RD_LAT(2), .FIFO_DEPTH(4)
  ) u_small (
    .clock(clock), .reset(reset), .start(s_start), .en(s_en), .rd_en(s_rd_en),
    .rd_solver_id(s_id), .rd_addr(s_addr), .rd_data(s_rd_data), .out_valid(s_valid),
    .out_ready(s_ready), .out_data(s_data), .out_col(s_col), .out_row(s_row),
    .out_sof(s_sof), .out_eol(s_eol), .out_eof(s_eof), .busy(s_busy), .done(s_done)
  );

  // Default-size instance: 7 solvers, 99x66.
  logic        d_start = 1'b0, d_en = 1'b0, d_ready = 1'b0;
  logic        d_rd_en, d_valid, d_sof, d_eol, d_eof, d_busy, d_done;
  logic [5:0]  d_id;
  logic [18:0] d_addr;
  logic [9:0]  d_rd_data, d_data, d_row;
  logic [10:0] d_col;
  logic [5:0]  d_p0_id = '0, d_p1_id = '0;
  logic [18:0] d_p0_ad = '0, d_p1_ad = '0;

  always @(posedge clock) begin
    d_p0_id <= d_id;
    d_p0_ad <= d_addr;
    d_p1_id <= d_p0_id;
    d_p1_ad <= d_p0_ad;
  end
  assign d_rd_data = mem_val(int'(d_p1_id), int'(d_p1_ad));

  pixel_stream_reader u_dflt (
    .clock(clock), .reset(reset), .start(d_start), .en(d_en), .rd_en(d_rd_en),
    .rd_solver_id(d_id), .rd_addr(d_addr), .rd_data(d_rd_data), .out_valid(d_valid),
    .out_ready(d_ready), .out_data(d_data), .out_col(d_col), .out_row(d_row),
    .out_sof(d_sof), .out_eol(d_eol), .out_eof(d_eof), .busy(d_busy), .done(d_done)
  );

  // One small frame with configurable ready duty, en schedule and stray start pulses.
  task automatic run_small_frame(input string name, input int ready_pct, input int en_from,
                                 input int gap_lo, input int gap_hi, input int restart_a,
                                 input int restart_b, output int first_valid,
                                 output int done_cyc);
    int          exp_id[8] = '{0, 1, 2, 0, 1, 2, 0, 1};
    int          exp_ad[8] = '{0, 0, 0, 1, 1, 1, 2, 2};
    int          nrd, nxf, ndone, eof_cyc, k;
    logic        stall, exp_busy;
    logic [9:0]  st_data, st_row;
    logic [10:0] st_col;
    logic [2:0]  st_flags;
    nrd = 0; nxf = 0; ndone = 0; eof_cyc = -100; first_valid = -1; done_cyc = -1;
    stall = 1'b0; st_data = '0; st_row = '0; st_col = '0; st_flags = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clock);
      s_start = (cyc == 0) || (cyc == restart_a) || (cyc == restart_b);
      s_en    = (cyc >= en_from) && !((cyc >= gap_lo) && (cyc < gap_hi));
      s_ready = (int'($urandom_range(99, 0)) < ready_pct);
      #1;
      if (stall) begin
        checks++;
        if ({s_valid, s_data, s_col, s_row, s_sof, s_eol, s_eof} !==
            {1'b1, st_data, st_col, st_row, st_flags}) begin
          failures++;
          $display("FAIL %s stall_hold cyc=%0d: got v=%b d=%0d c=%0d r=%0d, want v=1 d=%0d c=%0d r=%0d",
                   name, cyc, s_valid, s_data, s_col, s_row, st_data, st_col, st_row);
        end
      end
      checks++;
      if (nrd - nxf > 4) begin
        failures++;
        $display("FAIL %s outstanding cyc=%0d: got %0d, limit 4", name, cyc, nrd - nxf);
      end
      if (!s_en) begin
        checks++;
        if (s_rd_en !== 1'b0) begin
          failures++;
          $display("FAIL %s rd_en_while_en_low cyc=%0d: got %b want 0", name, cyc, s_rd_en);
        end
      end
      if (s_rd_en === 1'b1) begin
        checks++;
        if (nrd >= 8) begin
          failures++;
          $display("FAIL %s extra_read cyc=%0d: got read #%0d, want at most 8", name, cyc, nrd + 1);
        end else if ({s_id, s_addr} !== {6'(exp_id[nrd]), 19'(exp_ad[nrd])}) begin
          failures++;
          $display("FAIL %s read_addr #%0d: got id=%0d addr=%0d want id=%0d addr=%0d",
                   name, nrd, s_id, s_addr, exp_id[nrd], exp_ad[nrd]);
        end
        nrd++;
      end
      exp_busy = (cyc >= 1) && (ndone == 0) && (cyc != eof_cyc + 1);
      checks++;
      if (s_busy !== exp_busy) begin
        failures++;
        $display("FAIL %s busy cyc=%0d: got %b want %b", name, cyc, s_busy, exp_busy);
      end
      if (s_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (s_valid === 1'b1 && s_ready) begin
        checks++;
        if (nxf >= 8) begin
          failures++;
          $display("FAIL %s extra_transfer cyc=%0d: got transfer #%0d, want 8", name, cyc, nxf + 1);
        end else begin
          k = nxf;
          if ({s_data, s_col, s_row, s_sof, s_eol, s_eof} !==
              {mem_val(exp_id[k], exp_ad[k]), 11'(k % 4), 10'(k / 4), k == 0, (k % 4) == 3, k == 7})
          begin
            failures++;
            $display("FAIL %s pixel #%0d: got d=%0d c=%0d r=%0d sof/eol/eof=%b%b%b want d=%0d c=%0d r=%0d sof/eol/eof=%b%b%b",
                     name, k, s_data, s_col, s_row, s_sof, s_eol, s_eof,
                     mem_val(exp_id[k], exp_ad[k]), k % 4, k / 4, k == 0, (k % 4) == 3, k == 7);
          end
        end
        if (s_eof === 1'b1) eof_cyc = cyc;
        nxf++;
      end
      if (s_done === 1'b1) begin
        checks++;
        if (cyc != eof_cyc + 1 || ndone != 0) begin
          failures++;
          $display("FAIL %s done_timing: got done #%0d at cyc %0d, want single done at cyc %0d",
                   name, ndone + 1, cyc, eof_cyc + 1);
        end
        ndone++;
        done_cyc = cyc;
      end
      stall    = (s_valid === 1'b1) && !s_ready;
      st_data  = s_data;
      st_col   = s_col;
      st_row   = s_row;
      st_flags = {s_sof, s_eol, s_eof};
      if (ndone > 0 && cyc >= done_cyc + 5) break;
    end
    s_start = 1'b0;
    checks++;
    if (nxf != 8 || nrd != 8 || ndone != 1) begin
      failures++;
      $display("FAIL %s frame_totals: got reads=%0d xfers=%0d dones=%0d want 8/8/1",
               name, nrd, nxf, ndone);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    s_start = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if ({s_rd_en, s_id, s_addr, s_valid, s_data, s_col, s_row, s_sof, s_eol, s_eof, s_busy,
         s_done} !== '0) begin
      failures++;
      $display("FAIL reset_small_outputs: got %h want 0", {s_rd_en, s_id, s_addr, s_valid,
               s_data, s_col, s_row, s_sof, s_eol, s_eof, s_busy, s_done});
    end
    checks++;
    if ({d_rd_en, d_id, d_addr, d_valid, d_data, d_col, d_row, d_sof, d_eol, d_eof, d_busy,
         d_done} !== '0) begin
      failures++;
      $display("FAIL reset_dflt_outputs: got %h want 0", {d_rd_en, d_id, d_addr, d_valid,
               d_data, d_col, d_row, d_sof, d_eol, d_eof, d_busy, d_done});
    end
    @(negedge clock);
    s_start = 1'b0;
    reset   = 1'b1;
    @(negedge clock);
    #1;
    checks++;
    if (s_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle: got busy=%b want 0", s_busy);
    end
  endtask

  task automatic test_basic_frame();
    int fv, dc;
    run_small_frame("basic", 100, 0, 1000, 1000, -1, -1, fv, dc);
    checks++;
    if (fv != 4) begin
      failures++;
      $display("FAIL basic first_valid_latency: got %0d want 4", fv);
    end
    checks++;
    if (dc != 12) begin
      failures++;
      $display("FAIL basic frame_cycles: got %0d want 12", dc);
    end
  endtask

  task automatic test_backpressure();
    int fv, dc;
    run_small_frame("backpressure_a", 30, 0, 1000, 1000, -1, -1, fv, dc);
    run_small_frame("backpressure_b", 30, 0, 1000, 1000, -1, -1, fv, dc);
  endtask

  task automatic test_en_gaps();
    int fv, dc;
    run_small_frame("en_gaps", 100, 10, 12, 17, -1, -1, fv, dc);
    checks++;
    if (fv != 13) begin
      failures++;
      $display("FAIL en_gaps first_valid: got %0d want 13", fv);
    end
    checks++;
    if (dc != 26) begin
      failures++;
      $display("FAIL en_gaps done_cycle: got %0d want 26", dc);
    end
  endtask

  task automatic test_start_ignored();
    int fv, dc;
    run_small_frame("start_ignored", 100, 0, 1000, 1000, 2, 10, fv, dc);
    checks++;
    if (dc != 12) begin
      failures++;
      $display("FAIL start_ignored done_cycle: got %0d want 12", dc);
    end
  endtask

  task automatic test_reset_midframe();
    int fv, dc;
    @(negedge clock);
    s_start = 1'b1; s_en = 1'b1; s_ready = 1'b1;
    @(negedge clock);
    s_start = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if (s_valid !== 1'b1) begin
      failures++;
      $display("FAIL midframe_pre_reset_valid: got %b want 1", s_valid);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({s_rd_en, s_id, s_addr, s_valid, s_data, s_col, s_row, s_sof, s_eol, s_eof, s_busy,
         s_done} !== '0) begin
      failures++;
      $display("FAIL midframe_reset_outputs: got %h want 0", {s_rd_en, s_id, s_addr, s_valid,
               s_data, s_col, s_row, s_sof, s_eol, s_eof, s_busy, s_done});
    end
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      #1;
      checks++;
      if ({s_done, s_valid, s_busy, s_rd_en} !== 4'b0000) begin
        failures++;
        $display("FAIL midframe_quiet cyc=%0d: got done/valid/busy/rd_en=%b want 0000", i,
                 {s_done, s_valid, s_busy, s_rd_en});
      end
    end
    run_small_frame("after_reset", 100, 0, 1000, 1000, -1, -1, fv, dc);
    checks++;
    if (dc != 12) begin
      failures++;
      $display("FAIL after_reset done_cycle: got %0d want 12", dc);
    end
  endtask

  task automatic test_default_frame();
    int nrd, nxf, done_cyc, k, last_id, last_ad;
    nrd = 0; nxf = 0; done_cyc = -1; last_id = -1; last_ad = -1;
    for (int cyc = 0; cyc < 6600; cyc++) begin
      @(negedge clock);
      d_start = (cyc == 0);
      d_en    = 1'b1;
      d_ready = 1'b1;
      #1;
      if (d_rd_en === 1'b1) begin
        checks++;
        if ({d_id, d_addr} !== {6'(nrd % 7), 19'(nrd / 7)}) begin
          failures++;
          $display("FAIL dflt read_addr #%0d: got id=%0d addr=%0d want id=%0d addr=%0d",
                   nrd, d_id, d_addr, nrd % 7, nrd / 7);
        end
        last_id = int'(d_id);
        last_ad = int'(d_addr);
        nrd++;
      end
      if (d_valid === 1'b1 && d_ready) begin
        k = nxf;
        checks++;
        if ({d_data, d_col, d_row, d_sof, d_eol, d_eof} !==
            {mem_val(k % 7, k / 7), 11'(k % 99), 10'(k / 99), k == 0, (k % 99) == 98, k == 6533})
        begin
          failures++;
          $display("FAIL dflt pixel #%0d: got d=%0d c=%0d r=%0d flags=%b%b%b want d=%0d c=%0d r=%0d",
                   k, d_data, d_col, d_row, d_sof, d_eol, d_eof, mem_val(k % 7, k / 7),
                   k % 99, k / 99);
        end
        nxf++;
      end
      if (d_done === 1'b1 && done_cyc < 0) done_cyc = cyc;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    d_start = 1'b0;
    checks++;
    if (nxf != 6534 || nrd != 6534) begin
      failures++;
      $display("FAIL dflt totals: got reads=%0d xfers=%0d want 6534/6534", nrd, nxf);
    end
    checks++;
    if (last_id != 2 || last_ad != 933) begin
      failures++;
      $display("FAIL dflt last_read: got id=%0d addr=%0d want id=2 addr=933", last_id, last_ad);
    end
    checks++;
    if (done_cyc != 6538) begin
      failures++;
      $display("FAIL dflt done_cycle: got %0d want 6538", done_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_en_gaps();
    test_start_ignored();
    test_reset_midframe();
    test_default_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
